mem_request_arbiter: RTL

- Memory-side responder for the datapath request unit.
- Accepts instruction-fetch requests (imemREN) and data requests (dmemREN/dmemWEN), then serializes them onto a single-ported RAM.
- Returns one-cycle ihit/dhit pulses with load data.
- Sits between the datapath/request unit and the RAM model.

---
 rtl/mem_request_arbiter.sv | 179 +++++++++++++++++
 1 files changed

// File: rtl/mem_request_arbiter.sv
// Serializes instruction-fetch and data requests onto one single-ported RAM, returning ihit/dhit pulses.
// Optional macro MEM_FAIRNESS_EN: after three data grants while imemREN is held, the next grant goes to instruction.
//
// state | meaning
// IDLE  | arbitrate between data and instruction requests
// DACC  | data access on the RAM, strobe held until ACCESS/ERROR/timeout
// IACC  | instruction access on the RAM, same completion rules
// DRESP | dhit pulse, dmemload presents the registered load data
// IRESP | ihit pulse, imemload presents the registered load data
module mem_request_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 64
) (
  input  logic              CLK,
  input  logic              nRST,
  input  logic              imemREN,
  input  logic [ADDR_W-1:0] imemaddr,
  output logic              ihit,
  output logic [DATA_W-1:0] imemload,
  input  logic              dmemREN,
  input  logic              dmemWEN,
  input  logic [ADDR_W-1:0] dmemaddr,
  input  logic [DATA_W-1:0] dmemstore,
  output logic              dhit,
  output logic [DATA_W-1:0] dmemload,
  output logic              ramREN,
  output logic              ramWEN,
  output logic [ADDR_W-1:0] ramaddr,
  output logic [DATA_W-1:0] ramstore,
  input  logic [DATA_W-1:0] ramload,
  input  logic [1:0]        ramstate,
  output logic              mem_err
);

  localparam int CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(TIMEOUT - 1);
  localparam logic [1:0] RS_ACCESS = 2'd2;
  localparam logic [1:0] RS_ERROR  = 2'd3;

  typedef enum logic [2:0] {IDLE, DACC, IACC, DRESP, IRESP} state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] store_q, store_d;
  logic [CNT_W-1:0]  wait_q, wait_d;
  logic              ren_q, ren_d;
  logic              wen_q, wen_d;
  logic              ihit_q, ihit_d;
  logic              dhit_q, dhit_d;
  logic [DATA_W-1:0] imemload_q, imemload_d;
  logic [DATA_W-1:0] dmemload_q, dmemload_d;
  logic              err_q, err_d;
  logic              take_data;
  logic              acc_done;
  logic              acc_bad;
  logic [DATA_W-1:0] acc_load;
`ifdef MEM_FAIRNESS_EN
  logic [1:0]        fair_q, fair_d;
`endif

  always_comb begin
`ifdef MEM_FAIRNESS_EN
    take_data = (dmemREN | dmemWEN) & ~(imemREN & (fair_q == 2'd3));
`else
    take_data = dmemREN | dmemWEN;
`endif
    // ACCESS wins over a timeout that lands on the same cycle
    acc_done = (ramstate == RS_ACCESS) || (ramstate == RS_ERROR) || (wait_q == WAIT_LAST);
    acc_bad  = (ramstate != RS_ACCESS);
    acc_load = acc_bad ? '0 : ramload;
  end

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    store_d    = store_q;
    wait_d     = wait_q;
    ren_d      = 1'b0;
    wen_d      = 1'b0;
    ihit_d     = 1'b0;
    dhit_d     = 1'b0;
    imemload_d = imemload_q;
    dmemload_d = dmemload_q;
    err_d      = err_q;
    case (state_q)
      IDLE: begin
        if (take_data) begin
          addr_d  = dmemaddr;
          store_d = dmemstore;
          wait_d  = '0;
          wen_d   = dmemWEN;
          ren_d   = ~dmemWEN;
          state_d = DACC;
        end else if (imemREN) begin
          addr_d  = imemaddr;
          wait_d  = '0;
          ren_d   = 1'b1;
          state_d = IACC;
        end
      end
      DACC, IACC: begin
        if (acc_done) begin
          err_d = err_q | acc_bad;
          if (state_q == DACC) begin
            dmemload_d = acc_load;
            dhit_d     = 1'b1;
            state_d    = DRESP;
          end else begin
            imemload_d = acc_load;
            ihit_d     = 1'b1;
            state_d    = IRESP;
          end
        end else begin
          ren_d = ren_q;
          wen_d = wen_q;
          if (wait_q != WAIT_LAST) wait_d = wait_q + 1'b1;
        end
      end
      DRESP, IRESP: state_d = IDLE;
      default:      state_d = IDLE;
    endcase
  end

`ifdef MEM_FAIRNESS_EN
  always_comb begin
    fair_d = fair_q;
    if (state_q == IDLE) begin
      if (take_data && imemREN) fair_d = (fair_q == 2'd3) ? fair_q : fair_q + 2'd1;
      else                      fair_d = 2'd0;
    end
  end
`endif

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      store_q    <= '0;
      wait_q     <= '0;
      ren_q      <= 1'b0;
      wen_q      <= 1'b0;
      ihit_q     <= 1'b0;
      dhit_q     <= 1'b0;
      imemload_q <= '0;
      dmemload_q <= '0;
      err_q      <= 1'b0;
`ifdef MEM_FAIRNESS_EN
      fair_q     <= 2'd0;
`endif
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      store_q    <= store_d;
      wait_q     <= wait_d;
      ren_q      <= ren_d;
      wen_q      <= wen_d;
      ihit_q     <= ihit_d;
      dhit_q     <= dhit_d;
      imemload_q <= imemload_d;
      dmemload_q <= dmemload_d;
      err_q      <= err_d;
`ifdef MEM_FAIRNESS_EN
      fair_q     <= fair_d;
`endif
    end
  end

  assign ramREN   = ren_q;
  assign ramWEN   = wen_q;
  assign ramaddr  = addr_q;
  assign ramstore = store_q;
  assign ihit     = ihit_q;
  assign dhit     = dhit_q;
  assign imemload = imemload_q;
  assign dmemload = dmemload_q;
  assign mem_err  = err_q;

endmodule
